// File: rtl/single_digit_timer_pkg.sv
// Shared constants and the load clamp helper for single_digit_timer.
package single_digit_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DIGIT_MAX_UNITS = 9;
  localparam int unsigned DIGIT_MAX_TENS  = 5;

  function automatic int unsigned clamp(input int unsigned value, input int unsigned max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after each 0->1 on in.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q, in_d;
  logic pulse_q, pulse_d;

  always_comb begin
    in_d    = in;
    pulse_d = in & ~in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      in_q    <= in_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/single_digit_timer.sv
// One BCD digit of a cascaded countdown timer with borrow chaining and timeout.
// Define SDT_DECREMENT_EDGE_EN to count one decrement per rising edge of Decrement.
module single_digit_timer
  import single_digit_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_VALUE = DIGIT_MAX_UNITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] binaryInp,
  input  logic             InpLoad,
  input  logic             NoBorrow,
  input  logic             Decrement,
  output logic [WIDTH-1:0] BinaryOut,
  output logic             borrowReq,
  output logic             TOut
);

  localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             dec_req;

`ifdef SDT_DECREMENT_EDGE_EN
  rise_edge_detect u_dec_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (Decrement),
    .pulse (dec_req)
  );
`else
  assign dec_req = Decrement;
`endif

  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    if (InpLoad) begin
      count_d = WIDTH'(clamp(32'(binaryInp), MAX_VALUE));
    end else if (dec_req) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (!NoBorrow) begin
        // Underflow with a lender available: wrap and ask the next digit up.
        count_d  = MaxW;
        borrow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
    end
  end

  assign BinaryOut = count_q;
  assign borrowReq = borrow_q;
  assign TOut      = (count_q == '0) && NoBorrow;

endmodule

// File: tb/tb_single_digit_timer.sv
// Directed table-driven bench for single_digit_timer (units and tens instances).
module tb_single_digit_timer;
  import single_digit_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, InpLoad, NoBorrow, Decrement;
  logic [3:0] binaryInp;
  logic [3:0] out_u, out_t;
  logic       brw_u, brw_t, tout_u, tout_t;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  single_digit_timer #(.WIDTH(4), .MAX_VALUE(DIGIT_MAX_UNITS)) u_units (
    .clk(clk), .rst(rst), .binaryInp(binaryInp), .InpLoad(InpLoad), .NoBorrow(NoBorrow),
    .Decrement(Decrement), .BinaryOut(out_u), .borrowReq(brw_u), .TOut(tout_u)
  );

  single_digit_timer #(.WIDTH(4), .MAX_VALUE(DIGIT_MAX_TENS)) u_tens (
    .clk(clk), .rst(rst), .binaryInp(binaryInp), .InpLoad(InpLoad), .NoBorrow(NoBorrow),
    .Decrement(Decrement), .BinaryOut(out_t), .borrowReq(brw_t), .TOut(tout_t)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic [3:0] inp;
    logic       nb;
    logic       dec;
    logic [3:0] exp_out;
    logic       exp_brw;
    logic       exp_tout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic l, input logic [3:0] i,
                     input logic nb, input logic d, input logic [3:0] eo, input logic eb,
                     input logic et);
    vec_t v;
    v.name = n; v.rst = r; v.load = l; v.inp = i; v.nb = nb; v.dec = d;
    v.exp_out = eo; v.exp_brw = eb; v.exp_tout = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] i, input logic nb,
                       input logic d);
    @(negedge clk);
    rst = r; InpLoad = l; binaryInp = i; NoBorrow = nb; Decrement = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; InpLoad = 1'b0; binaryInp = '0; NoBorrow = 1'b0; Decrement = 1'b0;

    //   name          rst load inp nb dec  out brw tout
    add("reset0",      1, 1, 4'd5,  1, 1, 4'd0, 0, 1);
    add("reset1",      1, 0, 4'd0,  0, 1, 4'd0, 0, 0);
    add("load3",       0, 1, 4'd3,  0, 0, 4'd3, 0, 0);
    add("dec_to2",     0, 0, 4'd0,  0, 1, 4'd2, 0, 0);
    add("idle2",       0, 0, 4'd0,  0, 0, 4'd2, 0, 0);
    add("dec_to1",     0, 0, 4'd0,  0, 1, 4'd1, 0, 0);
    add("dec_to0",     0, 0, 4'd0,  0, 1, 4'd0, 0, 0);
    add("wrap9",       0, 0, 4'd0,  0, 1, 4'd9, 1, 0);
    add("idle9",       0, 0, 4'd0,  0, 0, 4'd9, 0, 0);
    add("nb_load3",    0, 1, 4'd3,  1, 0, 4'd3, 0, 0);
    add("nb_dec2",     0, 0, 4'd0,  1, 1, 4'd2, 0, 0);
    add("nb_dec1",     0, 0, 4'd0,  1, 1, 4'd1, 0, 0);
    add("nb_dec0",     0, 0, 4'd0,  1, 1, 4'd0, 0, 1);
    add("nb_stop0a",   0, 0, 4'd0,  1, 1, 4'd0, 0, 1);
    add("nb_stop0b",   0, 0, 4'd0,  1, 1, 4'd0, 0, 1);
    add("nb_fall",     0, 0, 4'd0,  0, 0, 4'd0, 0, 0);
    add("load_clamp",  0, 1, 4'd12, 0, 1, 4'd9, 0, 0);
    add("load4",       0, 1, 4'd4,  0, 0, 4'd4, 0, 0);
    add("rst_mid",     1, 0, 4'd0,  0, 1, 4'd0, 0, 0);
    add("tout_follow", 0, 0, 4'd0,  1, 0, 4'd0, 0, 1);
    add("load0",       0, 1, 4'd0,  0, 0, 4'd0, 0, 0);
    add("wrap_again",  0, 0, 4'd0,  0, 1, 4'd9, 1, 0);
    add("no_dbl_brw",  0, 0, 4'd0,  0, 1, 4'd8, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].load, vecs[k].inp, vecs[k].nb, vecs[k].dec);
      check({vecs[k].name, ".out"},  int'(out_u),  int'(vecs[k].exp_out));
      check({vecs[k].name, ".brw"},  int'(brw_u),  int'(vecs[k].exp_brw));
      check({vecs[k].name, ".tout"}, int'(tout_u), int'(vecs[k].exp_tout));
    end

    // Combinational TOut: load a nonzero value while NoBorrow stays high.
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("tout_at0", int'(tout_u), 1);
    @(negedge clk); InpLoad = 1'b1; binaryInp = 4'd2;
    @(posedge clk); #1;
    check("tout_after_load", int'(tout_u), 0);

    // Held decrement: 5 cycles after loading 7.
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef SDT_DECREMENT_EDGE_EN
    check("held_dec", int'(out_u), 6);
`else
    check("held_dec", int'(out_u), 2);
`endif

    // Clamp with load and decrement together on both digit flavours.
    drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    check("clamp_units", int'(out_u), 9);
    check("clamp_tens",  int'(out_t), 5);

    // Tens digit wraps to 5 on borrow.
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("tens_wrap",     int'(out_t), 5);
    check("tens_wrap_brw", int'(brw_t), 1);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("tens_brw_clear", int'(brw_t), 0);

    // Reset mid-count at 4 with Decrement held.
    drive(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    check("pre_rst4", int'(out_u), 4);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("rst4_out",  int'(out_u), 0);
    check("rst4_brw",  int'(brw_u), 0);
    check("rst4_tout", int'(tout_u), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
